// File: rtl/data_bus_bridge.sv
// Stalls the CPU while one data access runs on a waitrequest/readdatavalid bus.
// Define DATA_BUS_BRIDGE_TIMEOUT_EN to abort stuck accesses and flag bus_error.
module data_bus_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_clk_enable,
  output logic        cpu_clk_enable,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata,
  input  logic        bus_readdatavalid,
  output logic        bus_error
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQ       = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_eff;
  logic        dir_wr;
  logic [31:0] rdata_reg;
  logic        access;
  logic        tmo;

  assign access = cpu_data_read | cpu_data_write;

  // Reset behaves as IDLE combinationally, before the next edge lands.
  assign state_eff = reset ? IDLE : state;

  assign cpu_clk_enable = host_clk_enable &
    (((state_eff == IDLE) & ~access) | (state_eff == DONE));

  assign cpu_data_readdata = rdata_reg;

`ifdef DATA_BUS_BRIDGE_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;

  // Reaches 255 on the same edge that forces DONE.
  assign tmo = (tmo_cnt == 8'd254) &
    ((state == REQ) | (state == WAIT_DATA));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && access)
        tmo_cnt <= 8'd0;
      else if (state == REQ || state == WAIT_DATA)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (tmo && !(state == REQ && !bus_waitrequest)
              && !(state == WAIT_DATA && bus_readdatavalid))
        err_q <= 1'b1;
    end
  end

  assign bus_error = err_q;
`else
  assign tmo       = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dir_wr        <= 1'b0;
      bus_read      <= 1'b0;
      bus_write     <= 1'b0;
      bus_address   <= 32'd0;
      bus_writedata <= 32'd0;
      rdata_reg     <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access) begin
            bus_address   <= cpu_data_address;
            bus_writedata <= cpu_data_writedata;
            dir_wr        <= cpu_data_write;
            bus_write     <= cpu_data_write;
            bus_read      <= ~cpu_data_write;
            state         <= REQ;
          end
        end
        REQ: begin
          if (!bus_waitrequest) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            state     <= dir_wr ? DONE : WAIT_DATA;
          end else if (tmo) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            rdata_reg <= 32'hDEADBEEF;
            state     <= DONE;
          end
        end
        WAIT_DATA: begin
          if (bus_readdatavalid) begin
            rdata_reg <= bus_readdata;
            state     <= DONE;
          end else if (tmo) begin
            rdata_reg <= 32'hDEADBEEF;
            state     <= DONE;
          end
        end
        DONE: begin
          if (host_clk_enable)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
